// File: rtl/collision_engine.sv
// Purpose: per-frame breakout collision resolver (bricks, walls, paddle) updating ball velocity, score and end flags.
// Latency: start-to-done NUM_BRICKS+3 cycles (one brick per SCAN cycle, EDGE, UPDATE, then a one-cycle done pulse).
// Backpressure: none; start_i is dropped while busy_o, game_over_o or win_o is high.
module collision_engine #(
  parameter int NUM_BRICKS = 8,
  parameter int COORD_W    = 10,
  parameter int BALL_SZ    = 20,
  parameter int BRICK_W    = 58,
  parameter int BRICK_H    = 20,
  parameter int PADDLE_W   = 63,
  parameter int PADDLE_Y   = 458,
  parameter int FIELD_L    = 133,
  parameter int FIELD_R    = 505,
  parameter int FIELD_T    = 0,
  parameter int FIELD_B    = 459,
  parameter int DX_MAX     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [COORD_W-1:0]            ball_x_i,
  input  logic [COORD_W-1:0]            ball_y_i,
  input  logic [COORD_W-1:0]            paddle_x_i,
  input  logic [NUM_BRICKS*COORD_W-1:0] brick_x_i,
  input  logic [NUM_BRICKS*COORD_W-1:0] brick_y_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NUM_BRICKS-1:0]         alive_o,
  output logic [NUM_BRICKS-1:0]         hit_mask_o,
  output logic [3:0]                    dx_o,
  output logic [3:0]                    dy_o,
  output logic [15:0]                   score_o,
  output logic                          game_over_o,
  output logic                          win_o
);

  // One extra bit of headroom so that coordinate + size never wraps.
  localparam int CW    = COORD_W + 1;
  localparam int IDX_W = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_EDGE   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICKS - 1);

  localparam logic [CW-1:0] BALL_SZ_W   = CW'(BALL_SZ);
  localparam logic [CW-1:0] BALL_HALF_W = CW'(BALL_SZ / 2);
  localparam logic [CW-1:0] BRICK_R_W   = CW'(BRICK_W - 1);
  localparam logic [CW-1:0] BRICK_B_W   = CW'(BRICK_H - 1);
  localparam logic [CW-1:0] BRICK_H_W   = CW'(BRICK_H);
  localparam logic [CW-1:0] PAD_R_W     = CW'(PADDLE_W - 1);
  localparam logic [CW-1:0] PAD_T1_W    = CW'(PADDLE_W / 3);
  localparam logic [CW-1:0] PAD_T2_W    = CW'((2 * PADDLE_W) / 3);
  localparam logic [CW-1:0] PADDLE_Y_W  = CW'(PADDLE_Y);
  localparam logic [CW-1:0] FIELD_L_W   = CW'(FIELD_L);
  localparam logic [CW-1:0] FIELD_R_W   = CW'(FIELD_R);
  localparam logic [CW-1:0] FIELD_T_W   = CW'(FIELD_T);
  localparam logic [CW-1:0] FIELD_B_W   = CW'(FIELD_B);

  localparam logic signed [5:0] DX_MAX_S = 6'(DX_MAX);
  localparam logic signed [5:0] ONE_S    = 6'sd1;

  // FSM and sequencing
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             accept;

  // Frame snapshot of all coordinate inputs
  logic [COORD_W-1:0]                   bx_q, by_q, px_q;
  logic [NUM_BRICKS-1:0][COORD_W-1:0]   brx_q, bry_q;

  // Brick state and per-frame collision flags
  logic [NUM_BRICKS-1:0] alive_q, hit_q;
  logic                  flip_h_q, flip_v_q;
  logic                  pad_hit_q;
  logic [1:0]            zone_q;      // bit0: left third, bit1: right third

  // Persistent game state
  logic [3:0]  dx_q, dy_q, dx_d, dy_d;
  logic [15:0] score_q, score_d;
  logic        go_q, win_q, go_d, win_d;

  // Widened ball geometry
  logic [CW-1:0] ball_l, ball_r, ball_t, ball_b, ball_cx;
  // Current brick geometry
  logic [CW-1:0] br_l, br_r, br_t, br_b;
  logic          brick_overlap, centre_in;
  // Wall and paddle geometry
  logic [CW-1:0] pad_l, pad_r;
  logic          wall_h, wall_v, pad_hit, zone_left, zone_right;

  assign accept = (state_q == S_IDLE) && start_i && !go_q && !win_q;

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SCAN;
      S_SCAN:   if (idx_q == LAST_IDX) state_d = S_EDGE;
      S_EDGE:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register, brick index and the done pulse that follows UPDATE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_UPDATE);
      if (accept) begin
        idx_q <= '0;
      end else if (state_q == S_SCAN) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Snapshot inputs on an accepted start so mid-frame changes are invisible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q  <= '0;
      by_q  <= '0;
      px_q  <= '0;
      brx_q <= '0;
      bry_q <= '0;
    end else if (accept) begin
      bx_q  <= ball_x_i;
      by_q  <= ball_y_i;
      px_q  <= paddle_x_i;
      brx_q <= brick_x_i;
      bry_q <= brick_y_i;
    end
  end

  assign ball_l  = {1'b0, bx_q};
  assign ball_t  = {1'b0, by_q};
  assign ball_r  = ball_l + BALL_SZ_W;
  assign ball_b  = ball_t + BALL_SZ_W;
  assign ball_cx = ball_l + BALL_HALF_W;

  assign br_l = {1'b0, brx_q[idx_q]};
  assign br_t = {1'b0, bry_q[idx_q]};
  assign br_r = br_l + BRICK_R_W;
  assign br_b = br_t + BRICK_B_W;

  // A centre inside the brick's columns means the ball came through the top or bottom face.
  assign brick_overlap = alive_q[idx_q] && (ball_l <= br_r) && (ball_r >= br_l) &&
                         (ball_t <= br_b) && (ball_b >= br_t);
  assign centre_in     = (ball_cx >= br_l) && (ball_cx <= br_r);

  assign wall_h = (ball_l <= FIELD_L_W) || (ball_r >= FIELD_R_W);
  assign wall_v = (ball_t <= FIELD_T_W);

  assign pad_l      = {1'b0, px_q};
  assign pad_r      = pad_l + PAD_R_W;
  assign pad_hit    = (ball_b == PADDLE_Y_W) && (ball_l <= pad_r) && (ball_r >= pad_l);
  assign zone_left  = ball_cx < (pad_l + PAD_T1_W);
  assign zone_right = ball_cx >= (pad_l + PAD_T2_W);

  // Brick destruction during SCAN, wall/paddle flags during EDGE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q   <= '1;
      hit_q     <= '0;
      flip_h_q  <= 1'b0;
      flip_v_q  <= 1'b0;
      pad_hit_q <= 1'b0;
      zone_q    <= '0;
    end else if (accept) begin
      hit_q     <= '0;
      flip_h_q  <= 1'b0;
      flip_v_q  <= 1'b0;
      pad_hit_q <= 1'b0;
      zone_q    <= '0;
    end else if (state_q == S_SCAN) begin
      if (brick_overlap) begin
        alive_q[idx_q] <= 1'b0;
        hit_q[idx_q]   <= 1'b1;
        if (centre_in) begin
          flip_v_q <= 1'b1;
        end else begin
          flip_h_q <= 1'b1;
        end
      end
    end else if (state_q == S_EDGE) begin
      if (wall_h) flip_h_q <= 1'b1;
      if (wall_v) flip_v_q <= 1'b1;
      pad_hit_q <= pad_hit;
      zone_q    <= {zone_right, zone_left};
    end
  end

  logic signed [5:0] dx_s, dy_s, dx_flip, dx_adj, dx_sat, dx_new, dy_abs, dy_new;

  // Velocity: each axis flips at most once; paddle forces upward motion and steers dx by zone
  always_comb begin
    dx_s    = {{2{dx_q[3]}}, dx_q};
    dy_s    = {{2{dy_q[3]}}, dy_q};
    dx_flip = flip_h_q ? -dx_s : dx_s;
    dx_adj  = dx_flip;
    if (pad_hit_q) begin
      if (zone_q[0]) begin
        dx_adj = dx_flip - ONE_S;
      end else if (zone_q[1]) begin
        dx_adj = dx_flip + ONE_S;
      end
    end
    if (dx_adj > DX_MAX_S) begin
      dx_sat = DX_MAX_S;
    end else if (dx_adj < -DX_MAX_S) begin
      dx_sat = -DX_MAX_S;
    end else begin
      dx_sat = dx_adj;
    end
    // A stalled horizontal velocity would trap the ball; push it away from the paddle centre.
    dx_new = dx_sat;
    if (dx_sat == 6'sd0) begin
      dx_new = zone_q[1] ? ONE_S : -ONE_S;
    end
    dy_abs = dy_s[5] ? -dy_s : dy_s;
    if (pad_hit_q) begin
      dy_new = -dy_abs;
    end else if (flip_v_q) begin
      dy_new = -dy_s;
    end else begin
      dy_new = dy_s;
    end
    dx_d = dx_new[3:0];
    dy_d = dy_new[3:0];
  end

  logic [5:0]  hit_cnt;
  logic [16:0] score_sum;
  logic        low_brick;

  // Score, loss and win evaluation for the UPDATE cycle
  always_comb begin
    hit_cnt   = '0;
    low_brick = 1'b0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      hit_cnt = hit_cnt + 6'(hit_q[i]);
      if (alive_q[i] && (({1'b0, bry_q[i]} + BRICK_H_W) >= PADDLE_Y_W)) begin
        low_brick = 1'b1;
      end
    end
    score_sum = {1'b0, score_q} + 17'(hit_cnt);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    go_d      = go_q | (ball_b > FIELD_B_W) | low_brick;
    win_d     = win_q | (alive_q == '0);
  end

  // Commit velocity, score and sticky end flags once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q    <= 4'd1;
      dy_q    <= 4'd1;
      score_q <= '0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
    end else if (state_q == S_UPDATE) begin
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      score_q <= score_d;
      go_q    <= go_d;
      win_q   <= win_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign alive_o     = alive_q;
  assign hit_mask_o  = hit_q;
  assign dx_o        = dx_q;
  assign dy_o        = dy_q;
  assign score_o     = score_q;
  assign game_over_o = go_q;
  assign win_o       = win_q;

endmodule

// File: tb/tb_collision_engine.sv
// Purpose: scoreboard bench for collision_engine; an integer reference model predicts each frame's outcome.
// Latency: expects done exactly NUM_BRICKS+3 cycles after the accepting edge.
// Backpressure: checks that starts during busy, win or game_over are dropped.
module tb_collision_engine;
  localparam int NB = 8;

  typedef struct packed {
    logic [7:0]  alive;
    logic [7:0]  hit;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic [15:0] score;
    logic        go;
    logic        win;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [9:0]    ball_x, ball_y, paddle_x;
  logic [NB*10-1:0] brick_x, brick_y;
  logic          busy, done, game_over, win;
  logic [NB-1:0] alive, hit_mask;
  logic [3:0]    dx, dy;
  logic [15:0]   score;

  collision_engine dut (
    .clk(clk), .rst(rst), .start_i(start),
    .ball_x_i(ball_x), .ball_y_i(ball_y), .paddle_x_i(paddle_x),
    .brick_x_i(brick_x), .brick_y_i(brick_y),
    .busy_o(busy), .done_o(done), .alive_o(alive), .hit_mask_o(hit_mask),
    .dx_o(dx), .dy_o(dy), .score_o(score), .game_over_o(game_over), .win_o(win)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int br_x [NB];
  int br_y [NB];

  // reference model state
  logic [7:0] m_alive;
  int m_dx, m_dy, m_score;
  bit m_go, m_win;

  res_t sb_q[$];
  res_t obs, e;
  bit obs_done;
  int obs_lat;

  task automatic set_far();
    for (int i = 0; i < NB; i++) begin
      br_x[i] = 900;
      br_y[i] = 20;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_alive = 8'hFF; m_dx = 1; m_dy = 1; m_score = 0; m_go = 0; m_win = 0;
  endtask

  // Drive a frame request; when push is set, predict its outcome and queue it.
  task automatic begin_frame(input int bx, input int by, input int px, input bit push);
    logic [7:0] hits;
    bit fh, fv, ph;
    int cx, ndx, ndy;
    @(negedge clk);
    ball_x = bx[9:0];
    ball_y = by[9:0];
    paddle_x = px[9:0];
    for (int i = 0; i < NB; i++) begin
      brick_x[i*10 +: 10] = br_x[i][9:0];
      brick_y[i*10 +: 10] = br_y[i][9:0];
    end
    start = 1'b1;
    if (push) begin
      hits = '0; fh = 0; fv = 0;
      cx = bx + 10;
      for (int i = 0; i < NB; i++) begin
        if (m_alive[i] && bx <= br_x[i] + 57 && bx + 20 >= br_x[i] &&
            by <= br_y[i] + 19 && by + 20 >= br_y[i]) begin
          hits[i] = 1'b1;
          if (cx >= br_x[i] && cx <= br_x[i] + 57) fv = 1; else fh = 1;
        end
      end
      m_alive = m_alive & ~hits;
      if (bx <= 133 || bx + 20 >= 505) fh = 1;
      if (by <= 0) fv = 1;
      ph = (by + 20 == 458) && (bx <= px + 62) && (bx + 20 >= px);
      ndx = fh ? -m_dx : m_dx;
      if (ph) begin
        if (cx < px + 21) ndx = ndx - 1;
        else if (cx >= px + 42) ndx = ndx + 1;
        if (ndx > 5) ndx = 5;
        if (ndx < -5) ndx = -5;
        if (ndx == 0) ndx = (cx >= px + 42) ? 1 : -1;
        ndy = (m_dy < 0) ? m_dy : -m_dy;
      end else begin
        ndy = fv ? -m_dy : m_dy;
      end
      m_dx = ndx;
      m_dy = ndy;
      m_score = m_score + $countones(hits);
      if (m_score > 65535) m_score = 65535;
      if (by + 20 > 459) m_go = 1;
      for (int i = 0; i < NB; i++)
        if (m_alive[i] && br_y[i] + 20 >= 458) m_go = 1;
      if (m_alive == 8'h00) m_win = 1;
      e.alive = m_alive; e.hit = hits; e.dx = ndx[3:0]; e.dy = ndy[3:0];
      e.score = m_score[15:0]; e.go = m_go; e.win = m_win;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc_cnt;
  endtask

  // Poll for done with a cycle budget and capture the outputs.
  task automatic wait_done();
    int k;
    k = 0;
    obs_done = 0;
    while (!done && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done) begin
      obs_done = 1;
      obs_lat = cyc_cnt - acc_cyc + 1;
      obs.alive = alive; obs.hit = hit_mask; obs.dx = dx; obs.dy = dy;
      obs.score = score; obs.go = game_over; obs.win = win;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    n_chk++; if ({alive, hit_mask} !== 16'hFF00) begin n_fail++; $display("FAIL reset_alive_hit: got %h want ff00", {alive, hit_mask}); end
    n_chk++; if ({dx, dy, score} !== 24'h110000) begin n_fail++; $display("FAIL reset_vel_score: got %h want 110000", {dx, dy, score}); end
    n_chk++; if ({game_over, win} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {game_over, win}); end
  endtask

  task automatic test_single_hit();
    set_far();
    br_x[0] = 190; br_y[0] = 110;
    begin_frame(200, 100, 200, 1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_done();
    e = sb_q.pop_front();
    n_chk++; if (!obs_done) begin n_fail++; $display("FAIL single_done: no done within budget, want latency 11"); end
    n_chk++; if (obs_lat !== 11) begin n_fail++; $display("FAIL single_latency: got %0d want 11", obs_lat); end
    n_chk++; if (obs !== e) begin n_fail++; $display("FAIL single_result: got %h want %h", obs, e); end
    n_chk++; if ({obs.alive, obs.dx, obs.dy, obs.score} !== {8'hFE, 4'h1, 4'hF, 16'd1}) begin
      n_fail++; $display("FAIL single_literal: got %h want fe1f0001", {obs.alive, obs.dx, obs.dy, obs.score}); end
    @(posedge clk); #1;
    n_chk++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL single_pulse: got done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_walls();
    int wx[2];
    wx = '{485, 133};
    for (int k = 0; k < 2; k++) begin
      begin_frame(wx[k], 300, 200, 1);
      wait_done();
      e = sb_q.pop_front();
      n_chk++; if (!obs_done) begin n_fail++; $display("FAIL wall%0d_done: no done within budget", k); end
      n_chk++; if (obs !== e) begin n_fail++; $display("FAIL wall%0d_result: got %h want %h", k, obs, e); end
    end
    n_chk++; if ({obs.dx, obs.dy} !== 8'h1F) begin n_fail++; $display("FAIL wall_left_literal: got dx,dy=%h want 1f", {obs.dx, obs.dy}); end
  endtask

  task automatic test_paddle();
    int tx[8];
    int ty[8];
    tx = '{250, 250, 250, 250, 300, 250, 180, 215};
    ty = '{438, 438, 438, 438, 0, 438, 438, 438};
    set_far();
    for (int k = 0; k < 8; k++) begin
      begin_frame(tx[k], ty[k], 200, 1);
      wait_done();
      e = sb_q.pop_front();
      n_chk++; if (!obs_done) begin n_fail++; $display("FAIL paddle%0d_done: no done within budget", k); end
      n_chk++; if (obs !== e) begin n_fail++; $display("FAIL paddle%0d_result: got %h want %h", k, obs, e); end
      if (k == 5) begin
        n_chk++; if ({obs.dx, obs.dy} !== 8'h5F) begin n_fail++; $display("FAIL paddle_sat_literal: got dx,dy=%h want 5f", {obs.dx, obs.dy}); end
      end
      if (k == 6) begin
        n_chk++; if (obs.dx !== 4'h4) begin n_fail++; $display("FAIL paddle_left_literal: got dx=%h want 4", obs.dx); end
      end
    end
  endtask

  task automatic test_double_hit();
    set_far();
    br_x[2] = 300; br_y[2] = 200;
    br_x[3] = 300; br_y[3] = 225;
    begin_frame(310, 210, 200, 1);
    wait_done();
    e = sb_q.pop_front();
    n_chk++; if (!obs_done) begin n_fail++; $display("FAIL double_done: no done within budget"); end
    n_chk++; if (obs !== e) begin n_fail++; $display("FAIL double_result: got %h want %h", obs, e); end
    n_chk++; if ({obs.hit, obs.dy, obs.score} !== {8'h0C, 4'h1, 16'd3}) begin
      n_fail++; $display("FAIL double_literal: got %h want 0c10003", {obs.hit, obs.dy, obs.score}); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    set_far();
    begin_frame(300, 100, 200, 1);
    @(negedge clk); @(negedge clk);
    ball_x = 10'd905; ball_y = 10'd25; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    e = sb_q.pop_front();
    n_chk++; if (!obs_done) begin n_fail++; $display("FAIL busy_done: no done within budget"); end
    n_chk++; if (obs_lat !== 11) begin n_fail++; $display("FAIL busy_latency: got %0d want 11", obs_lat); end
    n_chk++; if (obs !== e) begin n_fail++; $display("FAIL busy_result: got %h want %h", obs, e); end
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL busy_ignored: got %0d busy/done cycles want 0", ndone); end
  endtask

  task automatic test_reset_mid_scan();
    int ndone;
    set_far();
    br_x[1] = 300; br_y[1] = 100;
    begin_frame(310, 100, 200, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if ({busy, done, alive} !== 10'h0FF) begin n_fail++; $display("FAIL abort_state: got busy,done,alive=%h want 0ff", {busy, done, alive}); end
    @(negedge clk);
    rst = 1'b0;
    m_alive = 8'hFF; m_dx = 1; m_dy = 1; m_score = 0; m_go = 0; m_win = 0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", ndone); end
    n_chk++; if ({alive, hit_mask, dx, dy, score} !== 40'hFF00110000) begin
      n_fail++; $display("FAIL abort_regs: got %h want ff00110000", {alive, hit_mask, dx, dy, score}); end
  endtask

  task automatic test_win_game_over();
    int nbusy;
    set_far();
    for (int i = 0; i < 7; i++) begin br_x[i] = 300; br_y[i] = 200; end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin br_x[7] = 300; br_y[7] = 200; end
      begin_frame(310, 210, 200, 1);
      wait_done();
      e = sb_q.pop_front();
      n_chk++; if (!obs_done) begin n_fail++; $display("FAIL win%0d_done: no done within budget", k); end
      n_chk++; if (obs !== e) begin n_fail++; $display("FAIL win%0d_result: got %h want %h", k, obs, e); end
    end
    n_chk++; if ({obs.alive, obs.win, obs.go} !== 10'b0000000010) begin
      n_fail++; $display("FAIL win_literal: got alive,win,go=%b want 0000000010", {obs.alive, obs.win, obs.go}); end
    for (int k = 0; k < 3; k++) begin
      nbusy = 0;
      if (k == 1) begin
        do_reset();
        set_far();
        begin_frame(300, 445, 200, 1);
      end else if (k == 2) begin
        do_reset();
        set_far();
        br_y[5] = 440;
        begin_frame(300, 100, 200, 1);
      end
      if (k != 0) begin
        wait_done();
        e = sb_q.pop_front();
        n_chk++; if (!obs_done) begin n_fail++; $display("FAIL over%0d_done: no done within budget", k); end
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL over%0d_result: got %h want %h", k, obs, e); end
        n_chk++; if ({obs.go, obs.win} !== 2'b10) begin n_fail++; $display("FAIL over%0d_flags: got go,win=%b want 10", k, {obs.go, obs.win}); end
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (busy || done) nbusy++;
        @(negedge clk);
      end
      n_chk++; if (nbusy !== 0) begin n_fail++; $display("FAIL end%0d_start_ignored: got %0d busy cycles want 0", k, nbusy); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    ball_x = '0; ball_y = '0; paddle_x = '0; brick_x = '0; brick_y = '0;
    m_alive = 8'hFF; m_dx = 1; m_dy = 1; m_score = 0; m_go = 0; m_win = 0;
    test_reset();
    test_single_hit();
    test_walls();
    test_paddle();
    test_double_hit();
    test_back_to_back();
    test_reset_mid_scan();
    test_win_game_over();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/collision_engine.md
COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 Parameter NUM_BRICKS, default 8, number of bricks scanned per frame (1..32).
REQ-002 Parameter COORD_W, default 10, unsigned coordinate width.
REQ-003 Parameters BALL_SZ 20, BRICK_W 58, BRICK_H 20, PADDLE_W 63, PADDLE_Y 458, object sizes/paddle top row in pixels.
REQ-004 Parameters FIELD_L 133, FIELD_R 505, FIELD_T 0, FIELD_B 459, playfield bounds.
REQ-005 Parameter DX_MAX, default 5, maximum |dx|.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  one-cycle frame request; samples all coordinate inputs.
REQ-009 ball_x, ball_y  in  COORD_W each  ball top-left.
REQ-010 paddle_x  in  COORD_W  paddle left edge.
REQ-011 brick_x, brick_y  in  NUM_BRICKS*COORD_W each  packed brick top-left, brick i at bits [i*COORD_W +: COORD_W].
REQ-012 busy  out  1  frame evaluation in progress.
REQ-013 done  out  1  one-cycle pulse, results valid.
REQ-014 alive  out  NUM_BRICKS  brick still present.
REQ-015 hit_mask  out  NUM_BRICKS  bricks destroyed in last frame.
REQ-016 dx, dy  out  4 each  signed two's-complement ball velocity.
REQ-017 score  out  16  destroyed-brick count.
REQ-018 game_over, win  out  1 each  sticky end-of-game flags.

Function
REQ-019 FSM states IDLE, SCAN, EDGE, UPDATE; IDLE->SCAN on start while not game_over and not win; SCAN->EDGE after brick NUM_BRICKS-1; EDGE->UPDATE; UPDATE->IDLE.
REQ-020 start shall be ignored while busy, game_over or win; busy=1 in SCAN, EDGE, UPDATE.
REQ-021 On accepted start, all inputs shall be latched; later input changes do not affect the frame.
REQ-022 SCAN shall evaluate exactly one brick per cycle, index 0 upward; done asserts in the cycle after UPDATE; start-to-done latency NUM_BRICKS+3 cycles.
REQ-023 Overlap of brick i: alive[i] and ball_x<=bx+BRICK_W-1 and ball_x+BALL_SZ>=bx and ball_y<=by+BRICK_H-1 and ball_y+BALL_SZ>=by, computed at COORD_W+1 bits, no wrap.
REQ-024 Overlapping brick: clear alive[i], set hit_mask[i]; if ball centre x (ball_x+BALL_SZ/2) lies within [bx, bx+BRICK_W-1] flag vertical hit, else horizontal hit.
REQ-025 Multiple hits in one frame: each axis flips at most once (OR of flags); all overlapping bricks destroyed.
REQ-026 EDGE: ball_x<=FIELD_L or ball_x+BALL_SZ>=FIELD_R sets horizontal flag; ball_y<=FIELD_T sets vertical flag.
REQ-027 EDGE paddle hit: ball_y+BALL_SZ==PADDLE_Y and x-overlap with [paddle_x, paddle_x+PADDLE_W-1]; paddle hit forces dy=-|dy| and suppresses vertical flag.
REQ-028 Paddle zone by ball centre x: left third dx-=1, middle third unchanged, right third dx+=1; zone adjust applied after any horizontal flip.
REQ-029 dx saturates to [-DX_MAX, +DX_MAX]; a result of 0 becomes +1 in right third, -1 otherwise.
REQ-030 ball_y+BALL_SZ>FIELD_B, or any alive brick with by+BRICK_H>=PADDLE_Y, sets game_over in UPDATE; velocity still updated that frame.
REQ-031 hit_mask cleared on accepted start; score += popcount(hit_mask) in UPDATE, saturating at 16'hFFFF.
REQ-032 win sets in UPDATE when alive becomes all-zero; game_over and win both may set in the same frame.

Reset
REQ-033 rst async: state IDLE, alive all ones, hit_mask 0, dx=+1, dy=+1, score 0, busy/done/game_over/win 0; rst mid-frame aborts without done.

Verification
REQ-034 NUM_BRICKS=8; ball (200,100), brick0 (190,110), others far -> done at cycle 11, alive=8'hFE, dy=-1, dx=+1, score 1.
REQ-035 Ball (133,300), dx=-1, no bricks hit -> dx=+1, dy unchanged.
REQ-036 Ball y=438, paddle_x=200, ball_x=250 (right third), dx=+5, dy=+1 -> dx=+5 saturated, dy=-1.
REQ-037 Ball overlapping bricks 2 and 3 both vertically -> hit_mask=8'h0C, dy flips once, score +2.
REQ-038 start asserted during busy and rst asserted mid-SCAN -> start ignored; reset yields IDLE, alive=8'hFF, no done pulse.
REQ-039 Destroy last alive brick -> win=1, later start ignored; ball_y=445 -> game_over=1.
